stream_mux: RTL

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_pkg.sv | 22 ++
 rtl/stream_mux_rr_arbiter.sv | 63 ++++++
 rtl/stream_mux.sv | 131 +++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg -- shared types and constants for the stream multiplexer.
//   mode_e             : arbitration mode (MODE_FIXED = sel-driven, MODE_RR = round-robin)
//   DEFAULT_NUM_INPUTS : default channel count
//   DEFAULT_WIDTH      : default data bits per channel
//   idx_w()            : width of a channel index for a given channel count
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEFAULT_NUM_INPUTS = 4;
    localparam int DEFAULT_WIDTH      = 8;

    // A single channel still needs a one-bit index so that port vectors
    // never collapse to zero width.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter -- round-robin request arbiter with a rotating priority pointer.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset (ptr -> 0)
//   req        : request vector, one bit per channel
//   advance    : a grant was consumed; move ptr just past the granted index
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : binary index of the granted channel
//   grant_vld  : some channel is granted
// The search starts at ptr and wraps from N-1 back to 0.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N  = DEFAULT_NUM_INPUTS,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [IW-1:0] ptr;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a variable unassigned and infers a latch.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!grant_vld && req[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_vld) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/stream_mux.sv
// stream_mux -- N-to-1 valid/ready stream multiplexer with a registered output.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_data    : per-channel data (unpacked array)
//   in_valid   : per-channel valid
//   in_ready   : per-channel accept strobe (at most one bit high)
//   sel        : channel select used in FIXED mode
//   mode       : 0 = FIXED (sel-driven), 1 = RR (round-robin)
//   out_data   : registered selected word
//   out_valid  : out_data holds an unconsumed word
//   out_ready  : downstream accept
//   out_src    : channel index that supplied out_data
// Optional (macro STREAM_MUX_PKT_LOCK_EN):
//   in_last    : per-channel end-of-packet marker
//   out_last   : end-of-packet marker registered alongside out_data
//   With the macro, the grant stays on one channel from its first word until
//   a word with in_last high, ignoring mode and sel meanwhile.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 in_data [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic [idx_w(NUM_INPUTS)-1:0]     sel,
    input  logic                             mode,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [idx_w(NUM_INPUTS)-1:0]     out_src
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [NUM_INPUTS-1:0]            in_last,
    output logic                             out_last
`endif
);

    localparam int IW = idx_w(NUM_INPUTS);

    mode_e                 mode_q;
    logic [NUM_INPUTS-1:0] sel_mask;
    logic [NUM_INPUTS-1:0] req;
    logic [NUM_INPUTS-1:0] grant;
    logic [IW-1:0]         grant_idx;
    logic                  grant_vld;
    logic                  load_en;
    logic                  xfer;
    logic                  advance;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic                  locked;
    logic [IW-1:0]         lock_src;
    logic [NUM_INPUTS-1:0] lock_mask;
`endif

    assign mode_q  = mode_e'(mode);
    assign load_en = !out_valid || out_ready;

    // All grant decisions go through the round-robin search: FIXED mode and
    // packet lock simply mask the request vector down to a single channel,
    // so the arbiter returns that channel (or nothing). An out-of-range sel
    // matches no bit and therefore yields no grant.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            sel_mask[i] = (int'(sel) == i);
        end
        req = (mode_q == MODE_RR) ? in_valid : (in_valid & sel_mask);
`ifdef STREAM_MUX_PKT_LOCK_EN
        lock_mask = '0;
        lock_mask[lock_src] = 1'b1;
        if (locked) begin
            req = in_valid & lock_mask;
        end
`endif
    end

    assign xfer     = grant_vld && load_en && !rst;
    assign in_ready = xfer ? grant : '0;
    assign advance  = xfer && (mode_q == MODE_RR);

    rr_arbiter #(
        .N  (NUM_INPUTS),
        .IW (IW)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // A held word (out_valid && !out_ready) keeps load_en low, so data, source
    // and valid all stay put; an empty load with out_ready high drops valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load_en) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= in_data[grant_idx];
                out_src  <= grant_idx;
            end
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_last <= 1'b0;
            locked   <= 1'b0;
            lock_src <= '0;
        end else if (xfer) begin
            out_last <= in_last[grant_idx];
            locked   <= !in_last[grant_idx];
            lock_src <= grant_idx;
        end else if (load_en) begin
            out_last <= 1'b0;
        end
    end
`endif

endmodule
